mips_multicycle: RTL and testbench

Parametrised multicycle MIPS core: the successor of the single-cycle core, sharing one memory port for instructions and data. A state-machine controller executes each instruction over 3–5 cycles. All memory accesses use a req/ready handshake, so the memory may insert wait states. It implements the same instruction subset (R-type add/sub/and/or/slt/sllv, lw, sw, beq, addi, j), adds an illegal-opcode trap, and sits between the testbench/top level and a unified memory model.

---
 rtl/mips_mc_pkg.sv | 51 +++++
 rtl/mc_ctrl.sv | 143 ++++++++++++++
 rtl/mips_multicycle.sv | 100 ++++++++++
 tb/tb_mips_multicycle.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS core: FSM states, opcodes,
// funct codes, ALU control and ALU operand-B selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLLV = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_SIMM  = 2'd1;
    localparam logic [1:0] SRCB_BRIMM = 2'd2;
    localparam logic [1:0] SRCB_ZIMM  = 2'd3;

    // Returns {valid, alu_ctl} for an R-type funct field.
    function automatic logic [3:0] funct_decode(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return {1'b1, ALU_ADD};
            FN_SUB:  return {1'b1, ALU_SUB};
            FN_AND:  return {1'b1, ALU_AND};
            FN_OR:   return {1'b1, ALU_OR};
            FN_SLT:  return {1'b1, ALU_SLT};
            FN_SLLV: return {1'b1, ALU_SLLV};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multicycle controller: sequences each instruction and drives datapath selects/enables.
// Defining MIPS_MC_IMMLOGIC_EN adds andi/ori through the ADDIEX/ADDIWB path.
// IDLE:after reset | FETCH:read instr | DECODE:read rs/rt, branch target | MEMADR:ld/st addr
// MEMRD/MEMWB:load+writeback | MEMWR:store | EXEC/ALUWB:R-type | BRANCH:beq
// ADDIEX/ADDIWB:imm ALU op | JUMP:j | TRAP:illegal instr, held until reset
module mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       trap,
    output logic       ir_we,
    output logic       ab_we,
    output logic       aluout_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic       rf_dst_rd,
    output logic       rf_src_mdr,
    output logic       branch,
    output logic       jump,
    output logic       alu_src_pc,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctl
);

    state_t     state;
    state_t     state_nxt;
    logic       funct_ok;
    logic [2:0] funct_ctl;

    assign {funct_ok, funct_ctl} = funct_decode(funct);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH:  if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXEC;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_ADDI:      state_nxt = ADDIEX;
`ifdef MIPS_MC_IMMLOGIC_EN
                    OP_ANDI, OP_ORI: state_nxt = ADDIEX;
`endif
                    OP_J:         state_nxt = JUMP;
                    default:      state_nxt = TRAP;
                endcase
            end
            MEMADR: state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_nxt = MEMWB;
            MEMWR:  if (mem_ready) state_nxt = FETCH;
            EXEC:   state_nxt = funct_ok ? ALUWB : TRAP;
            ADDIEX: state_nxt = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_nxt = FETCH;
            TRAP:   state_nxt = TRAP;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobes are registered from the next state so they appear with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            iord    <= 1'b0;
            trap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_req <= (state_nxt == FETCH) || (state_nxt == MEMRD) || (state_nxt == MEMWR);
            mem_we  <= (state_nxt == MEMWR);
            iord    <= (state_nxt == MEMRD) || (state_nxt == MEMWR);
            trap    <= trap || (state_nxt == TRAP);
        end
    end

    always_comb begin
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        aluout_we  = 1'b0;
        mdr_we     = 1'b0;
        rf_we      = 1'b0;
        rf_dst_rd  = 1'b0;
        rf_src_mdr = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src_pc = 1'b0;
        alu_src_b  = SRCB_B;
        alu_ctl    = ALU_ADD;
        case (state)
            FETCH:  ir_we = mem_ready;
            DECODE: begin
                ab_we      = 1'b1;
                aluout_we  = 1'b1;
                alu_src_pc = 1'b1;
                alu_src_b  = SRCB_BRIMM;
            end
            MEMADR: begin
                aluout_we = 1'b1;
                alu_src_b = SRCB_SIMM;
            end
            MEMRD:  mdr_we = mem_ready;
            MEMWB:  begin
                rf_we      = 1'b1;
                rf_src_mdr = 1'b1;
            end
            EXEC:   begin
                aluout_we = 1'b1;
                alu_ctl   = funct_ctl;
            end
            ALUWB:  begin
                rf_we     = 1'b1;
                rf_dst_rd = 1'b1;
            end
            ADDIEX: begin
                aluout_we = 1'b1;
                alu_src_b = SRCB_SIMM;
`ifdef MIPS_MC_IMMLOGIC_EN
                if (op == OP_ANDI) begin
                    alu_src_b = SRCB_ZIMM;
                    alu_ctl   = ALU_AND;
                end else if (op == OP_ORI) begin
                    alu_src_b = SRCB_ZIMM;
                    alu_ctl   = ALU_OR;
                end
`endif
            end
            ADDIWB: rf_we  = 1'b1;
            BRANCH: branch = 1'b1;
            JUMP:   jump   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core with a single req/ready memory port shared by fetch and data.
// Defining MIPS_MC_IMMLOGIC_EN enables andi/ori; otherwise those opcodes trap.
module mips_multicycle
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       pc,
    output logic              trap
);

    logic [31:0] ir, a, b, aluout, mdr;
    logic [31:0] rf [0:31];
    logic        iord, ir_we, ab_we, aluout_we, mdr_we, rf_we, rf_dst_rd, rf_src_mdr;
    logic        branch, jump, alu_src_pc;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctl;
    logic [31:0] signimm, alu_a, alu_b, alu_y, addr_full, rs_val, rt_val;
    logic [4:0]  rf_waddr;

    mc_ctrl u_ctrl (
        .clk(clk), .reset(reset), .op(ir[31:26]), .funct(ir[5:0]), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .trap(trap),
        .ir_we(ir_we), .ab_we(ab_we), .aluout_we(aluout_we), .mdr_we(mdr_we),
        .rf_we(rf_we), .rf_dst_rd(rf_dst_rd), .rf_src_mdr(rf_src_mdr),
        .branch(branch), .jump(jump), .alu_src_pc(alu_src_pc),
        .alu_src_b(alu_src_b), .alu_ctl(alu_ctl)
    );

    assign signimm   = {{16{ir[15]}}, ir[15:0]};
    assign rs_val    = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
    assign rt_val    = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];
    assign rf_waddr  = rf_dst_rd ? ir[15:11] : ir[20:16];
    assign addr_full = iord ? aluout : pc;
    // Address/data are forced to zero when idle so the bus is quiet outside requests.
    assign mem_addr  = mem_req ? addr_full[ADDR_W-1:0] : '0;
    assign mem_wdata = mem_we ? b : 32'd0;

    assign alu_a = alu_src_pc ? pc : a;
    always_comb begin
        case (alu_src_b)
            SRCB_SIMM:  alu_b = signimm;
            SRCB_BRIMM: alu_b = {signimm[29:0], 2'b00};
            SRCB_ZIMM:  alu_b = {16'd0, ir[15:0]};
            default:    alu_b = b;
        endcase
    end

    always_comb begin
        case (alu_ctl)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLLV: alu_y = alu_b << alu_a[4:0];
            default:  alu_y = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= 32'd0;
            a      <= 32'd0;
            b      <= 32'd0;
            aluout <= 32'd0;
            mdr    <= 32'd0;
        end else begin
            if (ir_we) begin
                ir <= mem_rdata;
                pc <= pc + 32'd4;
            end else if (jump) begin
                pc <= {pc[31:28], ir[25:0], 2'b00};
            end else if (branch && (a == b)) begin
                pc <= aluout;
            end
            if (ab_we) begin
                a <= rs_val;
                b <= rt_val;
            end
            if (aluout_we) aluout <= alu_y;
            if (mdr_we)    mdr    <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && (rf_waddr != 5'd0)) rf[rf_waddr] <= rf_src_mdr ? mdr : aluout;
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: runs small programs from a wait-state memory model
// and checks fetch trace, per-instruction cycle counts, stores, trap and reset behaviour.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    mips_multicycle #(.RESET_PC(32'h40), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .pc(pc), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          cycles;
        bit          wr;
        logic [31:0] wa;
        logic [31:0] wd;
    } vec_t;

    vec_t        tbl [0:25];
    logic [31:0] mem [0:255];
    logic [31:0] f_addr [0:63];
    int          f_cyc [0:63];
    logic [31:0] w_addr [0:15];
    logic [31:0] w_data [0:15];
    int          f_n, w_n, req_n, cyc, wait_cnt, wait_seen;
    int          wait_n;
    logic [31:0] wait_addr;
    int          vectors, errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        f_n = 0; w_n = 0; req_n = 0; wait_cnt = 0; wait_seen = 0;
    endtask

    // One clock: at the falling edge decide ready/rdata for the handshake at the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (reset || !mem_req) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else begin
            req_n++;
            if (mem_addr == wait_addr && wait_cnt < wait_n) begin
                mem_ready = 1'b0;
                wait_cnt++;
                wait_seen++;
            end else begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) begin
                    if (w_n < 16) begin
                        w_addr[w_n] = mem_addr;
                        w_data[w_n] = mem_wdata;
                    end
                    w_n++;
                    mem[mem_addr[9:2]] = mem_wdata;
                end else if (mem_addr < 32'h300) begin
                    if (f_n < 64) begin
                        f_addr[f_n] = mem_addr;
                        f_cyc[f_n]  = cyc;
                    end
                    f_n++;
                end
            end
        end
    endtask

    initial begin
        int j;
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'd0;
        vectors = 0; errors = 0; cyc = 0;
        wait_n = 3; wait_addr = 32'h304;
        clear_logs();

        //           addr       instr         cyc wr  waddr      wdata
        tbl[0]  = '{32'h040, 32'h20080005, 4, 0, 32'h0,   32'h0};        // addi $8,$0,5
        tbl[1]  = '{32'h044, 32'h20090007, 4, 0, 32'h0,   32'h0};        // addi $9,$0,7
        tbl[2]  = '{32'h048, 32'h01095020, 4, 0, 32'h0,   32'h0};        // add $10,$8,$9
        tbl[3]  = '{32'h04C, 32'hAC0A0300, 4, 1, 32'h300, 32'h0000000C};
        tbl[4]  = '{32'h050, 32'h8C0B0304, 8, 0, 32'h0,   32'h0};        // lw, 3 wait states
        tbl[5]  = '{32'h054, 32'hAC0B0308, 4, 1, 32'h308, 32'hDEADBEEF};
        tbl[6]  = '{32'h058, 32'h01096022, 4, 0, 32'h0,   32'h0};        // sub $12
        tbl[7]  = '{32'h05C, 32'hAC0C030C, 4, 1, 32'h30C, 32'hFFFFFFFE};
        tbl[8]  = '{32'h060, 32'h0188682A, 4, 0, 32'h0,   32'h0};        // slt $13,$12,$8
        tbl[9]  = '{32'h064, 32'hAC0D0310, 4, 1, 32'h310, 32'h00000001};
        tbl[10] = '{32'h068, 32'h010C702A, 4, 0, 32'h0,   32'h0};        // slt $14,$8,$12
        tbl[11] = '{32'h06C, 32'hAC0E0314, 4, 1, 32'h314, 32'h00000000};
        tbl[12] = '{32'h070, 32'h01497824, 4, 0, 32'h0,   32'h0};        // and $15
        tbl[13] = '{32'h074, 32'hAC0F0318, 4, 1, 32'h318, 32'h00000004};
        tbl[14] = '{32'h078, 32'h01498025, 4, 0, 32'h0,   32'h0};        // or $16
        tbl[15] = '{32'h07C, 32'hAC10031C, 4, 1, 32'h31C, 32'h0000000F};
        tbl[16] = '{32'h080, 32'h01098804, 4, 0, 32'h0,   32'h0};        // sllv $17,$9,$8
        tbl[17] = '{32'h084, 32'hAC110320, 4, 1, 32'h320, 32'h000000E0};
        tbl[18] = '{32'h088, 32'h20000063, 4, 0, 32'h0,   32'h0};        // addi $0,$0,99
        tbl[19] = '{32'h08C, 32'hAC000324, 4, 1, 32'h324, 32'h00000000};
        tbl[20] = '{32'h090, 32'h08000080, 3, 0, 32'h0,   32'h0};        // j 0x200
        tbl[21] = '{32'h200, 32'h08000040, 3, 0, 32'h0,   32'h0};        // j 0x100
        tbl[22] = '{32'h100, 32'h1109FFFF, 3, 0, 32'h0,   32'h0};        // beq unequal
        tbl[23] = '{32'h104, 32'h11080001, 3, 0, 32'h0,   32'h0};        // beq taken +1
        tbl[24] = '{32'h10C, 32'h1108FFFF, 3, 0, 32'h0,   32'h0};        // beq -1 loop
        tbl[25] = '{32'h10C, 32'h1108FFFF, 3, 0, 32'h0,   32'h0};

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 26; i++) mem[tbl[i].addr[9:2]] = tbl[i].instr;
        mem[32'h108 >> 2] = 32'hFC000000;
        mem[32'h304 >> 2] = 32'hDEADBEEF;

        step(); step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_pc", pc, 32'h40);
        chk("rst_trap", {31'd0, trap}, 32'd0);

        reset = 1'b0;
        step();
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h40);

        for (int i = 0; i < 800 && f_n < 27; i++) step();
        chk("p1_fetches_done", {31'd0, f_n >= 27}, 32'd1);

        j = 0;
        for (int i = 0; i < 26; i++) begin
            chk($sformatf("v%0d_fetch_addr", i), f_addr[i], tbl[i].addr);
            chk($sformatf("v%0d_cycles", i), 32'(f_cyc[i+1] - f_cyc[i]), 32'(tbl[i].cycles));
            if (tbl[i].wr) begin
                chk($sformatf("v%0d_wr_addr", i), w_addr[j], tbl[i].wa);
                chk($sformatf("v%0d_wr_data", i), w_data[j], tbl[i].wd);
                j++;
            end
        end
        chk("first4_cycles", 32'(f_cyc[4] - f_cyc[0]), 32'd16);
        chk("lw_wait_cycles", 32'(wait_seen), 32'd3);
        chk("p1_write_count", 32'(w_n), 32'd9);
        chk("p1_no_trap", {31'd0, trap}, 32'd0);

        // Asynchronous reset in the middle of a request.
        for (int i = 0; i < 10 && !mem_req; i++) step();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_pc", pc, 32'h40);

        // Illegal opcode 0x3F at reset vector.
        step();
        mem[32'h40 >> 2] = 32'hFC000000;
        clear_logs();
        reset = 1'b0;
        repeat (20) step();
        chk("trap_set", {31'd0, trap}, 32'd1);
        chk("trap_pc", pc, 32'h44);
        chk("trap_req_count", 32'(req_n), 32'd1);

        // andi/ori program: traps on andi unless immediate logic is built in.
        reset = 1'b1;
        step();
        mem[32'h40 >> 2] = 32'h2008F0F0;   // addi $8,$0,0xF0F0
        mem[32'h44 >> 2] = 32'h310900FF;   // andi $9,$8,0x00FF
        mem[32'h48 >> 2] = 32'hAC0903B0;   // sw $9,0x3B0
        mem[32'h4C >> 2] = 32'h340A8001;   // ori $10,$0,0x8001
        mem[32'h50 >> 2] = 32'hAC0A03B4;   // sw $10,0x3B4
        mem[32'h54 >> 2] = 32'hFC000000;
        clear_logs();
        reset = 1'b0;
        for (int i = 0; i < 100 && !trap; i++) step();
        repeat (5) step();
        chk("imm_trap", {31'd0, trap}, 32'd1);
`ifdef MIPS_MC_IMMLOGIC_EN
        chk("imm_wr_count", 32'(w_n), 32'd2);
        chk("andi_wr_addr", w_addr[0], 32'h3B0);
        chk("andi_wr_data", w_data[0], 32'h000000F0);
        chk("ori_wr_addr", w_addr[1], 32'h3B4);
        chk("ori_wr_data", w_data[1], 32'h00008001);
        chk("andi_cycles", 32'(f_cyc[2] - f_cyc[1]), 32'd4);
        chk("imm_trap_pc", pc, 32'h58);
`else
        chk("andi_trap_pc", pc, 32'h48);
        chk("andi_trap_writes", 32'(w_n), 32'd0);
        chk("andi_trap_fetches", 32'(f_n), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
